// File: rtl/aes_pkg.sv
`default_nettype none
//==============================================================================
// Module   : aes_pkg
// Brief    : Shared AES-128 constants, FSM state type and GF(2^8) helpers.
// Revision : 1.0 - initial release
//==============================================================================
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } aes_fsm_t;

    // Entry 0 sits in the most significant byte so c_sbox[x] is S(x).
    localparam logic [0:255][7:0] c_sbox = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_sbox[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_comb.sv
`default_nettype none
//==============================================================================
// Module   : aes_round_comb
// Brief    : One combinational AES round; final round bypasses MixColumns.
// Revision : 1.0 - initial release
//==============================================================================
module aes_round_comb (
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_final_round,
    output logic [127:0] o_next_state
);
    import aes_pkg::*;

    // Byte n of the block lives in bits [127-8n -: 8]; column-major, row = n%4.
    logic [0:15][7:0] w_in;
    logic [0:15][7:0] w_sb;
    logic [0:15][7:0] w_sr;
    logic [0:15][7:0] w_mc;
    logic [0:15][7:0] w_pre_key;

    assign w_in = i_state;

    for (genvar n = 0; n < 16; n++) begin : g_sub
        assign w_sb[n] = sbox(w_in[n]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
        end

        assign w_mc[4*c+0] = gmul(w_sr[4*c+0], 8'h02) ^ gmul(w_sr[4*c+1], 8'h03) ^
                             w_sr[4*c+2] ^ w_sr[4*c+3];
        assign w_mc[4*c+1] = w_sr[4*c+0] ^ gmul(w_sr[4*c+1], 8'h02) ^
                             gmul(w_sr[4*c+2], 8'h03) ^ w_sr[4*c+3];
        assign w_mc[4*c+2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^
                             gmul(w_sr[4*c+2], 8'h02) ^ gmul(w_sr[4*c+3], 8'h03);
        assign w_mc[4*c+3] = gmul(w_sr[4*c+0], 8'h03) ^ w_sr[4*c+1] ^
                             w_sr[4*c+2] ^ gmul(w_sr[4*c+3], 8'h02);
    end

    assign w_pre_key    = i_final_round ? w_sr : w_mc;
    assign o_next_state = w_pre_key ^ i_round_key;

endmodule
`default_nettype wire

// File: rtl/aes_round_engine.sv
`default_nettype none
//==============================================================================
// Module   : aes_round_engine
// Brief    : Iterative AES-128 encryptor, one round per clock, valid/ready I/O.
// Revision : 1.0 - initial release
//==============================================================================
module aes_round_engine #(
    parameter int WIDTH = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    input  logic [WIDTH-1:0] plain_i,
    input  logic [WIDTH-1:0] key_0_i,
    input  logic [WIDTH-1:0] key_1_i,
    input  logic [WIDTH-1:0] key_2_i,
    input  logic [WIDTH-1:0] key_3_i,
    input  logic [WIDTH-1:0] key_4_i,
    input  logic [WIDTH-1:0] key_5_i,
    input  logic [WIDTH-1:0] key_6_i,
    input  logic [WIDTH-1:0] key_7_i,
    input  logic [WIDTH-1:0] key_8_i,
    input  logic [WIDTH-1:0] key_9_i,
    input  logic [WIDTH-1:0] key_10_i,
    output logic [WIDTH-1:0] ciph_o,
    output logic             ciph_valid_o,
    input  logic             ciph_ready_i,
    output logic             busy_o
);
    import aes_pkg::*;

    localparam logic [3:0] c_last_round = 4'(NUM_ROUNDS - 1);

    aes_fsm_t         r_fsm;
    aes_fsm_t         w_fsm_next;
    logic [WIDTH-1:0] r_state;
    logic [3:0]       r_rnd_cnt;
    logic [WIDTH-1:0] r_ciph;
    logic             r_ciph_valid;
    logic [WIDTH-1:0] w_round_key;
    logic [WIDTH-1:0] w_round_out;
    logic             w_final_round;

    assign w_final_round = (r_fsm == ST_FINAL);

    // rnd_cnt reaches 10 on entry to FINAL, which selects the last key.
    always_comb begin
        w_round_key = '0;
        case (r_rnd_cnt)
            4'd1:    w_round_key = key_1_i;
            4'd2:    w_round_key = key_2_i;
            4'd3:    w_round_key = key_3_i;
            4'd4:    w_round_key = key_4_i;
            4'd5:    w_round_key = key_5_i;
            4'd6:    w_round_key = key_6_i;
            4'd7:    w_round_key = key_7_i;
            4'd8:    w_round_key = key_8_i;
            4'd9:    w_round_key = key_9_i;
            4'd10:   w_round_key = key_10_i;
            default: w_round_key = '0;
        endcase
    end

    aes_round_comb u_round (
        .i_state       (r_state),
        .i_round_key   (w_round_key),
        .i_final_round (w_final_round),
        .o_next_state  (w_round_out)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_fsm <= ST_IDLE;
        else       r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            ST_IDLE:  if (data_valid_i) w_fsm_next = ST_ROUND;
            ST_ROUND: begin
                // An out-of-range counter means corrupted state: abandon the block.
                if (r_rnd_cnt == 4'd0 || r_rnd_cnt > c_last_round) w_fsm_next = ST_IDLE;
                else if (r_rnd_cnt == c_last_round)                 w_fsm_next = ST_FINAL;
            end
            ST_FINAL: w_fsm_next = ST_DONE;
            ST_DONE:  if (ciph_ready_i) w_fsm_next = ST_IDLE;
            default:  w_fsm_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= '0;
            r_rnd_cnt    <= 4'd0;
            r_ciph       <= '0;
            r_ciph_valid <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (data_valid_i) begin
                        r_state   <= plain_i ^ key_0_i;
                        r_rnd_cnt <= 4'd1;
                    end
                end
                ST_ROUND: begin
                    r_state   <= w_round_out;
                    r_rnd_cnt <= r_rnd_cnt + 4'd1;
                end
                ST_FINAL: begin
                    r_ciph       <= w_round_out;
                    r_ciph_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (ciph_ready_i) r_ciph_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign data_ready_o = (r_fsm == ST_IDLE);
    assign busy_o       = (r_fsm != ST_IDLE);
    assign ciph_o       = r_ciph;
    assign ciph_valid_o = r_ciph_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_engine.sv
`default_nettype none
//==============================================================================
// Module   : tb_aes_round_engine
// Brief    : Self-checking bench for aes_round_engine against an AES-128 model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_aes_round_engine;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         data_valid_i;
    logic         data_ready_o;
    logic [127:0] plain_i;
    logic [127:0] rk_drv [0:10];
    logic [127:0] ciph_o;
    logic         ciph_valid_o;
    logic         ciph_ready_i;
    logic         busy_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sb       [0:255];
    logic [127:0] rk_model [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] APPC_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] APPC_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] APPC_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_round_engine #(.WIDTH(128)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .plain_i      (plain_i),
        .key_0_i      (rk_drv[0]),
        .key_1_i      (rk_drv[1]),
        .key_2_i      (rk_drv[2]),
        .key_3_i      (rk_drv[3]),
        .key_4_i      (rk_drv[4]),
        .key_5_i      (rk_drv[5]),
        .key_6_i      (rk_drv[6]),
        .key_7_i      (rk_drv[7]),
        .key_8_i      (rk_drv[8]),
        .key_9_i      (rk_drv[9]),
        .key_10_i     (rk_drv[10]),
        .ciph_o       (ciph_o),
        .ciph_valid_o (ciph_valid_o),
        .ciph_ready_i (ciph_ready_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model: polynomial GF(2^8) arithmetic ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S(x) = affine(x^-1), derived from first principles rather than a table.
    task automatic build_sbox;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic ref_encrypt(input logic [127:0] key, input logic [127:0] pt, output logic [127:0] ct);
        logic [7:0] m    [4][4];
        logic [7:0] t    [4][4];
        logic [7:0] circ [4];
        logic [7:0] acc;
        circ = '{8'h02, 8'h03, 8'h01, 8'h01};
        expand_key(key);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk_model[0][127-8*(4*c+r) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb[m[r][c]];
            // row r rotates left by r positions
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    m[r][c] = t[r][(c + r) % 4];
            if (rnd != 10) begin
                t = m;
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(circ[(k - r + 4) % 4], t[k][c]);
                        m[r][c] = acc;
                    end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    m[r][c] = m[r][c] ^ rk_model[rnd][127-8*(4*c+r) -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                ct[127-8*(4*c+r) -: 8] = m[r][c];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_keys(input logic [127:0] key);
        expand_key(key);
        for (int i = 0; i < 11; i++) rk_drv[i] = rk_model[i];
    endtask

    // Called at a negedge; returns edges from accept to first valid (-1 if never accepted).
    task automatic run_block(input logic [127:0] pt, output logic [127:0] ct, output int lat);
        int waitc;
        waitc = 0;
        lat   = -1;
        ct    = '0;
        while (!data_ready_o && waitc < 40) begin
            @(negedge clk_i);
            waitc++;
        end
        if (!data_ready_o) return;
        plain_i      = pt;
        data_valid_i = 1'b1;
        @(negedge clk_i);
        data_valid_i = 1'b0;
        lat = 0;
        while (!ciph_valid_o && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        ct = ciph_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_i        = 1'b1;
        data_valid_i = 1'b0;
        ciph_ready_i = 1'b1;
        plain_i      = '0;
        for (int i = 0; i < 11; i++) rk_drv[i] = '0;
        repeat (3) @(negedge clk_i);
        checks++; if (ciph_o !== 128'h0) begin failures++; $display("FAIL reset_ciph got=%h exp=0", ciph_o); end
        checks++; if (ciph_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ciph_valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (data_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", data_ready_o); end
        @(negedge clk_i);
    endtask

    task automatic test_fips_vector;
        logic [127:0] ct;
        int lat;
        set_keys(FIPS_KEY);
        run_block(FIPS_PT, ct, lat);
        checks++; if (ct !== FIPS_CT) begin failures++; $display("FAIL fips_ct got=%h exp=%h", ct, FIPS_CT); end
        checks++; if (lat !== 10) begin failures++; $display("FAIL fips_latency got=%0d exp=10", lat); end
        @(negedge clk_i);
        checks++; if (data_ready_o !== 1'b1 || ciph_valid_o !== 1'b0) begin
            failures++; $display("FAIL fips_release got=ready%b/valid%b exp=ready1/valid0", data_ready_o, ciph_valid_o);
        end
    endtask

    task automatic test_appendix_c;
        logic [127:0] ct;
        int lat;
        set_keys(APPC_KEY);
        run_block(APPC_PT, ct, lat);
        checks++; if (ct !== APPC_CT) begin failures++; $display("FAIL appc_ct got=%h exp=%h", ct, APPC_CT); end
        checks++; if (lat !== 10) begin failures++; $display("FAIL appc_latency got=%0d exp=10", lat); end
        @(negedge clk_i);
    endtask

    task automatic test_backpressure;
        logic [127:0] ct;
        int lat;
        set_keys(FIPS_KEY);
        ciph_ready_i = 1'b0;
        run_block(FIPS_PT, ct, lat);
        checks++; if (lat !== 10) begin failures++; $display("FAIL bp_latency got=%0d exp=10", lat); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            checks++; if (ciph_o !== FIPS_CT) begin failures++; $display("FAIL bp_hold_ct cyc=%0d got=%h exp=%h", i, ciph_o, FIPS_CT); end
            checks++; if (ciph_valid_o !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, ciph_valid_o); end
            checks++; if (data_ready_o !== 1'b0) begin failures++; $display("FAIL bp_hold_ready cyc=%0d got=%b exp=0", i, data_ready_o); end
        end
        ciph_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (data_ready_o !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", data_ready_o); end
        checks++; if (ciph_valid_o !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", ciph_valid_o); end
    endtask

    task automatic test_ignore_valid;
        int lat;
        int waitc;
        set_keys(FIPS_KEY);
        waitc = 0;
        while (!data_ready_o && waitc < 40) begin @(negedge clk_i); waitc++; end
        plain_i      = FIPS_PT;
        data_valid_i = 1'b1;
        @(negedge clk_i);
        data_valid_i = 1'b0;
        lat = 0;
        while (!ciph_valid_o && lat < 40) begin
            if (lat == 3 || lat == 7) begin
                data_valid_i = 1'b1;
                plain_i      = {$urandom, $urandom, $urandom, $urandom};
                checks++; if (data_ready_o !== 1'b0) begin failures++; $display("FAIL ign_ready lat=%0d got=%b exp=0", lat, data_ready_o); end
            end else begin
                data_valid_i = 1'b0;
            end
            @(negedge clk_i);
            lat++;
        end
        data_valid_i = 1'b0;
        checks++; if (ciph_o !== FIPS_CT) begin failures++; $display("FAIL ign_ct got=%h exp=%h", ciph_o, FIPS_CT); end
        checks++; if (lat !== 10) begin failures++; $display("FAIL ign_latency got=%0d exp=10", lat); end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid;
        logic [127:0] ct;
        int lat;
        int waitc;
        logic saw_valid;
        set_keys(FIPS_KEY);
        waitc = 0;
        while (!data_ready_o && waitc < 40) begin @(negedge clk_i); waitc++; end
        plain_i      = FIPS_PT;
        data_valid_i = 1'b1;
        @(negedge clk_i);
        data_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", busy_o); end
        rst_i = 1'b1;
        #1;
        checks++; if (ciph_o !== 128'h0) begin failures++; $display("FAIL rmid_ciph got=%h exp=0", ciph_o); end
        checks++; if (ciph_valid_o !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", ciph_valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++; if (data_ready_o !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", data_ready_o); end
        saw_valid = 1'b0;
        repeat (15) begin
            @(negedge clk_i);
            if (ciph_valid_o) saw_valid = 1'b1;
        end
        checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_valid got=%b exp=0", saw_valid); end
        set_keys(APPC_KEY);
        run_block(APPC_PT, ct, lat);
        checks++; if (ct !== APPC_CT) begin failures++; $display("FAIL rmid_appc_ct got=%h exp=%h", ct, APPC_CT); end
        checks++; if (lat !== 10) begin failures++; $display("FAIL rmid_appc_latency got=%0d exp=10", lat); end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back;
        logic [127:0] key;
        logic [127:0] pts  [2];
        logic [127:0] exps [2];
        logic [127:0] got  [2];
        int acc  [2];
        int vcyc [2];
        int na;
        int nv;
        key    = {$urandom, $urandom, $urandom, $urandom};
        pts[0] = {$urandom, $urandom, $urandom, $urandom};
        pts[1] = {$urandom, $urandom, $urandom, $urandom};
        ref_encrypt(key, pts[0], exps[0]);
        ref_encrypt(key, pts[1], exps[1]);
        set_keys(key);
        acc  = '{0, 0};
        vcyc = '{0, 0};
        got  = '{128'h0, 128'h0};
        na = 0;
        nv = 0;
        ciph_ready_i = 1'b1;
        data_valid_i = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (ciph_valid_o && nv < 2) begin
                got[nv]  = ciph_o;
                vcyc[nv] = cyc;
                nv++;
            end
            if (data_ready_o) begin
                if (na < 2) begin
                    plain_i = pts[na];
                    acc[na] = cyc;
                    na++;
                end else begin
                    data_valid_i = 1'b0;
                end
            end
            @(negedge clk_i);
        end
        data_valid_i = 1'b0;
        checks++; if (na !== 2) begin failures++; $display("FAIL b2b_accepts got=%0d exp=2", na); end
        checks++; if (acc[1] - acc[0] !== 12) begin failures++; $display("FAIL b2b_spacing got=%0d exp=12", acc[1] - acc[0]); end
        checks++; if (nv !== 2) begin failures++; $display("FAIL b2b_results got=%0d exp=2", nv); end
        checks++; if (got[0] !== exps[0]) begin failures++; $display("FAIL b2b_ct0 got=%h exp=%h", got[0], exps[0]); end
        checks++; if (got[1] !== exps[1]) begin failures++; $display("FAIL b2b_ct1 got=%h exp=%h", got[1], exps[1]); end
        checks++; if (vcyc[0] - acc[0] !== 11) begin failures++; $display("FAIL b2b_lat0 got=%0d exp=11", vcyc[0] - acc[0]); end
        checks++; if (vcyc[1] - acc[1] !== 11) begin failures++; $display("FAIL b2b_lat1 got=%0d exp=11", vcyc[1] - acc[1]); end
    endtask

    task automatic test_random;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] exp_ct;
        logic [127:0] ct;
        int lat;
        for (int n = 0; n < 8; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            ref_encrypt(key, pt, exp_ct);
            set_keys(key);
            run_block(pt, ct, lat);
            checks++; if (ct !== exp_ct) begin failures++; $display("FAIL rand_ct n=%0d got=%h exp=%h", n, ct, exp_ct); end
            checks++; if (lat !== 10) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=10", n, lat); end
            @(negedge clk_i);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_vector();
        test_appendix_c();
        test_backpressure();
        test_ignore_valid();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
